push_pulse_bank: RTL and testbench

- Multi-channel successor to the single push-button one-pulse block used for round wins.
- Each channel synchronises a raw button, debounces it and emits a single-cycle registered event pulse.
- Edge mode is selectable per channel: rising, falling, both or disabled.
- Feeds the game controller, which needs clean per-player press events from several buttons at once.

---
 rtl/push_pulse_bank.sv | 166 ++++++++++++++++
 tb/tb_push_pulse_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/push_pulse_bank.sv
// push_pulse_bank: per-channel button synchroniser, debouncer and edge-event
// pulse generator. Each channel selects rise / fall / both / disabled events.
// Optional auto-repeat while a press is held is compiled in when the macro
// PUSH_REPEAT_EN is defined; the default build has no repeat logic.
module push_pulse_bank #(
    parameter int N             = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_DELAY  = 32,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   btn,
    input  logic [2*N-1:0] mode,
    output logic [N-1:0]   pulse,
    output logic [N-1:0]   level,
    output logic           any_pulse
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    // Reject parameter values the datapath cannot represent.
    if (N < 1 || SYNC_STAGES < 1 || DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("push_pulse_bank: all parameters must be >= 1");
    end

    // True when a transition to new_lvl is an enabled event for mode code m.
    function automatic logic edge_enabled(input logic [1:0] m, input logic new_lvl);
        logic en;
        case (m)
            2'b00:   en = new_lvl;
            2'b01:   en = ~new_lvl;
            2'b10:   en = 1'b1;
            2'b11:   en = 1'b0;
            default: en = 1'b0;
        endcase
        return en;
    endfunction

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  sync_d [SYNC_STAGES];
    logic [CW-1:0] cnt_q  [N];
    logic [CW-1:0] cnt_d  [N];
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  pulse_q, pulse_d;
    logic          any_pulse_q, any_pulse_d;
    logic [N-1:0]  s_s;
    logic [N-1:0]  accept_s;
    logic [N-1:0]  rep_fire_s;

    // Shift raw buttons through the synchroniser chain.
    always_comb begin
        sync_d[0] = btn;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s_s = sync_q[SYNC_STAGES-1];

    // Debounce: a new level is accepted after DEB_CYCLES consecutive mismatches.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i]    = cnt_q[i];
            level_d[i]  = level_q[i];
            accept_s[i] = 1'b0;
            if (s_s[i] == level_q[i]) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                level_d[i]  = s_s[i];
                cnt_d[i]    = {CW{1'b0}};
                accept_s[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

`ifdef PUSH_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt_q [N];
    logic [RW-1:0] rep_cnt_d [N];
    logic [N-1:0]  rep_arm_q, rep_arm_d;

    // Repeat timer: first fire after REPEAT_DELAY, then every REPEAT_PERIOD while held.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rep_cnt_d[i]  = rep_cnt_q[i];
            rep_arm_d[i]  = rep_arm_q[i];
            rep_fire_s[i] = 1'b0;
            if (!level_q[i] || accept_s[i] || !edge_enabled(mode[2*i +: 2], 1'b1)) begin
                rep_cnt_d[i] = {RW{1'b0}};
                rep_arm_d[i] = 1'b0;
            end else if (rep_cnt_q[i] == (rep_arm_q[i] ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
                rep_cnt_d[i]  = {RW{1'b0}};
                rep_arm_d[i]  = 1'b1;
                rep_fire_s[i] = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                rep_cnt_q[i] <= {RW{1'b0}};
            end
            rep_arm_q <= {N{1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
            rep_arm_q <= rep_arm_d;
        end
    end
`else
    assign rep_fire_s = {N{1'b0}};
`endif

    // Event pulse: mode is consulted only at the accept edge; repeats fill the rest.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (accept_s[i]) begin
                pulse_d[i] = edge_enabled(mode[2*i +: 2], s_s[i]);
            end else begin
                pulse_d[i] = rep_fire_s[i];
            end
        end
        any_pulse_d = |pulse_d;
    end

    // Main state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= {N{1'b0}};
            end
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
            level_q     <= {N{1'b0}};
            pulse_q     <= {N{1'b0}};
            any_pulse_q <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q     <= level_d;
            pulse_q     <= pulse_d;
            any_pulse_q <= any_pulse_d;
        end
    end

    assign pulse     = pulse_q;
    assign level     = level_q;
    assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_push_pulse_bank.sv
// Bench for push_pulse_bank: each scenario fills a stimulus schedule, a
// latency model derives the expected level/pulse per edge, expectations are
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_push_pulse_bank;

    localparam int N   = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = 6;   // SYNC_STAGES + DEB_CYCLES
    localparam int DB  = 4;
    localparam int LEN = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   btn;
    logic [2*N-1:0] mode;
    logic [N-1:0]   pulse;
    logic [N-1:0]   level;
    logic           any_pulse;

    typedef struct packed {
        logic [N-1:0] p;
        logic [N-1:0] l;
    } exp_t;

    exp_t         sb [$];
    exp_t         ex;
    logic [N-1:0] s_btn [LEN];
    logic         s_rst [LEN];
    logic [N-1:0] e_lvl [LEN+1];
    logic [N-1:0] e_pls [LEN+1];
    int           checks = 0;
    int           errors = 0;

    push_pulse_bank #(
        .N(N), .SYNC_STAGES(2), .DEB_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .mode(mode),
        .pulse(pulse), .level(level), .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    task automatic clear_sched();
        for (int k = 0; k < LEN; k++) begin
            s_btn[k] = '0;
            s_rst[k] = 1'b0;
        end
    endtask

    task automatic set_btn(input int ch, input int from, input int to, input logic v);
        for (int k = from; k < to; k++) s_btn[k][ch] = v;
    endtask

    // Expected outputs after edge e: a btn run starting at drive slot c that is
    // stable for DB slots and differs from the level is accepted at edge c+LAT.
    task automatic build_model(input logic [2*N-1:0] m_all, input int len);
        for (int ch = 0; ch < N; ch++) begin
            logic       lvl = 1'b0;
            logic       v, ok, pl;
            logic [1:0] m = m_all[2*ch +: 2];
            int         base = 0;
            logic       rep_on = 1'b0;
            int         next_rep = 0;
            for (int e = 1; e <= len; e++) begin
                int c = e - LAT;
                pl = 1'b0;
                if (s_rst[e-1]) begin
                    lvl = 1'b0; base = e; rep_on = 1'b0;
                end else begin
                    ok = 1'b0;
                    if (c >= base) begin
                        v  = s_btn[c][ch];
                        ok = (v != lvl);
                        for (int j = 1; j < DB; j++) if (s_btn[c+j][ch] != v) ok = 1'b0;
                        if (c > base && s_btn[c-1][ch] == v) ok = 1'b0;
                    end
                    if (ok) begin
                        lvl = v;
                        pl  = v ? (m == 2'b00 || m == 2'b10) : (m == 2'b01 || m == 2'b10);
                        rep_on   = v && (m == 2'b00 || m == 2'b10);
                        next_rep = e + RD;
                    end
`ifdef PUSH_REPEAT_EN
                    else if (rep_on && lvl && e == next_rep) begin
                        pl = 1'b1;
                        next_rep = e + RP;
                    end
`endif
                    if (!lvl) rep_on = 1'b0;
                end
                e_lvl[e][ch] = lvl;
                e_pls[e][ch] = pl;
            end
        end
    endtask

    task automatic drive(input int k);
        rst = s_rst[k];
        btn = s_btn[k];
        sb.push_back({e_pls[k+1], e_lvl[k+1]});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        btn = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mode = '0;
        for (int k = 0; k < 3; k++) begin
            rst = 1'b1;
            btn = 4'b1010;
            sb.push_back({4'b0000, 4'b0000});
            @(posedge clk); #1;
            ex = sb.pop_front();
            checks += 3;
            if (pulse !== ex.p) begin errors++; $display("FAIL reset pulse cyc %0d: got %b want %b", k, pulse, ex.p); end
            if (level !== ex.l) begin errors++; $display("FAIL reset level cyc %0d: got %b want %b", k, level, ex.l); end
            if (any_pulse !== 1'b0) begin errors++; $display("FAIL reset any_pulse cyc %0d: got %b want 0", k, any_pulse); end
        end
    endtask

    task automatic test_clean_press();
        clear_sched(); set_btn(0, 0, 20, 1'b1);
        mode = '0; build_model(mode, 40); apply_reset();
        for (int k = 0; k < 40; k++) begin
            drive(k); @(posedge clk); #1; ex = sb.pop_front(); checks += 3;
            if (pulse !== ex.p) begin errors++; $display("FAIL clean_press pulse edge %0d: got %b want %b", k+1, pulse, ex.p); end
            if (level !== ex.l) begin errors++; $display("FAIL clean_press level edge %0d: got %b want %b", k+1, level, ex.l); end
            if (any_pulse !== (|ex.p)) begin errors++; $display("FAIL clean_press any_pulse edge %0d: got %b want %b", k+1, any_pulse, |ex.p); end
        end
    endtask

    task automatic test_glitch();
        clear_sched(); set_btn(1, 2, 5, 1'b1); set_btn(1, 20, 24, 1'b1);
        mode = '0; build_model(mode, 40); apply_reset();
        for (int k = 0; k < 40; k++) begin
            drive(k); @(posedge clk); #1; ex = sb.pop_front(); checks += 3;
            if (pulse !== ex.p) begin errors++; $display("FAIL glitch pulse edge %0d: got %b want %b", k+1, pulse, ex.p); end
            if (level !== ex.l) begin errors++; $display("FAIL glitch level edge %0d: got %b want %b", k+1, level, ex.l); end
            if (any_pulse !== (|ex.p)) begin errors++; $display("FAIL glitch any_pulse edge %0d: got %b want %b", k+1, any_pulse, |ex.p); end
        end
    endtask

    task automatic test_modes();
        clear_sched();
        for (int ch = 1; ch < N; ch++) set_btn(ch, 1, 11, 1'b1);
        mode = 8'b11_10_01_00; build_model(mode, 30); apply_reset();
        for (int k = 0; k < 30; k++) begin
            drive(k); @(posedge clk); #1; ex = sb.pop_front(); checks += 3;
            if (pulse !== ex.p) begin errors++; $display("FAIL modes pulse edge %0d: got %b want %b", k+1, pulse, ex.p); end
            if (level !== ex.l) begin errors++; $display("FAIL modes level edge %0d: got %b want %b", k+1, level, ex.l); end
            if (any_pulse !== (|ex.p)) begin errors++; $display("FAIL modes any_pulse edge %0d: got %b want %b", k+1, any_pulse, |ex.p); end
        end
    endtask

    task automatic test_simultaneous();
        int n_any = 0;
        clear_sched();
        for (int ch = 0; ch < N; ch++) set_btn(ch, 0, 10, 1'b1);
        mode = '0; build_model(mode, 25); apply_reset();
        for (int k = 0; k < 25; k++) begin
            drive(k); @(posedge clk); #1; ex = sb.pop_front(); checks += 3;
            if (any_pulse === 1'b1) n_any++;
            if (pulse !== ex.p) begin errors++; $display("FAIL simul pulse edge %0d: got %b want %b", k+1, pulse, ex.p); end
            if (level !== ex.l) begin errors++; $display("FAIL simul level edge %0d: got %b want %b", k+1, level, ex.l); end
            if (any_pulse !== (|ex.p)) begin errors++; $display("FAIL simul any_pulse edge %0d: got %b want %b", k+1, any_pulse, |ex.p); end
        end
        checks++;
        if (n_any != 1) begin errors++; $display("FAIL simul any_pulse_cycles: got %0d want 1", n_any); end
    endtask

    task automatic test_reset_mid();
        clear_sched(); set_btn(0, 0, 30, 1'b1); s_rst[3] = 1'b1;
        mode = '0; build_model(mode, 30); apply_reset();
        for (int k = 0; k < 30; k++) begin
            drive(k); @(posedge clk); #1; ex = sb.pop_front(); checks += 3;
            if (pulse !== ex.p) begin errors++; $display("FAIL reset_mid pulse edge %0d: got %b want %b", k+1, pulse, ex.p); end
            if (level !== ex.l) begin errors++; $display("FAIL reset_mid level edge %0d: got %b want %b", k+1, level, ex.l); end
            if (any_pulse !== (|ex.p)) begin errors++; $display("FAIL reset_mid any_pulse edge %0d: got %b want %b", k+1, any_pulse, |ex.p); end
        end
    endtask

    task automatic test_hold();
        clear_sched(); set_btn(0, 0, 41, 1'b1);
        mode = '0; build_model(mode, 60); apply_reset();
        for (int k = 0; k < 60; k++) begin
            drive(k); @(posedge clk); #1; ex = sb.pop_front(); checks += 3;
            if (pulse !== ex.p) begin errors++; $display("FAIL hold pulse edge %0d: got %b want %b", k+1, pulse, ex.p); end
            if (level !== ex.l) begin errors++; $display("FAIL hold level edge %0d: got %b want %b", k+1, level, ex.l); end
            if (any_pulse !== (|ex.p)) begin errors++; $display("FAIL hold any_pulse edge %0d: got %b want %b", k+1, any_pulse, |ex.p); end
        end
    endtask

    initial begin
        rst  = 1'b1;
        btn  = '0;
        mode = '0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_modes();
        test_simultaneous();
        test_reset_mid();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
